pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the three-stage pipelined CPU: fetch/decode, execute, writeback.
- Watches the decode, execute and writeback register specifiers and detects RAW hazards.
- Drives operand-forwarding selects for the ALU A/B holding registers and handles load-use stalls.
- Flushes younger instructions when a branch resolves taken in writeback; the pipeline-register block consumes these controls.
- Clocked on the phase-0 rising edge, like the inter-stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 11 +
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
//   state_t       : controller states RUN / LDSTALL / FLUSH
//   FWD_*         : operand-forwarding select encodings
//   ZERO_REG_DEF  : default hard-wired zero register specifier
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2} state_t;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;
    localparam int ZERO_REG_DEF = 31;
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: forwarding select for one ALU operand
//   src/use_src          : decode source specifier and its read enable
//   ex_rd/ex_wen/ex_load : execute producer
//   wb_rd/wb_wen         : writeback producer
//   sel                  : FWD_RF / FWD_EX / FWD_WB
//   ex_hit               : execute match regardless of load (feeds load-use detection)
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    output logic [1:0]       sel,
    output logic             ex_hit
);
    logic wb_hit;
    always_comb begin
        ex_hit = use_src && ex_wen && (src == ex_rd) && (ex_rd != REG_W'(ZERO_REG));
        wb_hit = use_src && wb_wen && (src == wb_rd) && (wb_rd != REG_W'(ZERO_REG));
        // a load in execute has no data yet, so it never forwards from execute
        sel = (ex_hit && !ex_load) ? FWD_EX : wb_hit ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW hazard detection, forwarding, load-use stall and branch flush control
//   inputs : clk, Reset (sync, active-low), decode sources, execute/writeback destinations, br_taken
//   outputs: pc_hold, dec_hold, ex_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt, busy
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int ZERO_REG  = ZERO_REG_DEF,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    input  logic             br_taken,
    output logic             pc_hold,
    output logic             dec_hold,
    output logic             ex_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);
    localparam int DW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    state_t           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flushc_q, flushc_d;
    logic [1:0]       sel_a, sel_b;
    logic             hit_a, hit_b, load_use;
    logic             pc_hold_c, dec_hold_c, ex_bubble_c, flush_c;

    fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src(dec_rs1), .use_src(dec_use1), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .sel(sel_a), .ex_hit(hit_a)
    );
    fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src(dec_rs2), .use_src(dec_use2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .sel(sel_b), .ex_hit(hit_b)
    );

    assign load_use = dec_valid && ex_load && (hit_a || hit_b);

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        stall_d     = stall_q;
        flushc_d    = flushc_q;
        pc_hold_c   = 1'b0;
        dec_hold_c  = 1'b0;
        ex_bubble_c = 1'b0;
        flush_c     = 1'b0;
        case (state_q)
            RUN, LDSTALL: begin
                if (br_taken) begin
                    // FLUSH_CYC=1 means the detection cycle is the whole flush
                    flush_c  = 1'b1;
                    state_d  = (FLUSH_CYC > 1) ? FLUSH : RUN;
                    dcnt_d   = DW'(FLUSH_CYC - 1);
                    flushc_d = (flushc_q == '1) ? flushc_q : flushc_q + 1'b1;
                end else if (state_q == RUN && load_use) begin
                    pc_hold_c   = 1'b1;
                    dec_hold_c  = 1'b1;
                    ex_bubble_c = 1'b1;
                    state_d     = LDSTALL;
                    stall_d     = (stall_q == '1) ? stall_q : stall_q + 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // writeback holds a bubble here, so br_taken and hazards are ignored
                flush_c     = 1'b1;
                ex_bubble_c = 1'b1;
                dcnt_d      = dcnt_q - 1'b1;
                state_d     = (dcnt_d == '0) ? RUN : FLUSH;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q  <= RUN;
            dcnt_q   <= '0;
            stall_q  <= '0;
            flushc_q <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            stall_q  <= stall_d;
            flushc_q <= flushc_d;
        end
    end

    assign pc_hold   = Reset && pc_hold_c;
    assign dec_hold  = Reset && dec_hold_c;
    assign ex_bubble = Reset && ex_bubble_c;
    assign flush     = Reset && flush_c;
    assign busy      = Reset && (state_q != RUN);
    assign fwd_a     = Reset ? sel_a : FWD_RF;
    assign fwd_b     = Reset ? sel_b : FWD_RF;
    assign stall_cnt = Reset ? stall_q : '0;
    assign flush_cnt = Reset ? flushc_q : '0;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic Reset;
    logic dec_valid, dec_use1, dec_use2, ex_wen, ex_load, wb_wen, br_taken;
    logic [4:0] dec_rs1, dec_rs2, ex_rd, wb_rd;
    logic pc_hold, dec_hold, ex_bubble, flush, busy;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_hold, s_dec_hold, s_ex_bubble, s_flush, s_busy;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [3:0] s_stall_cnt, s_flush_cnt;
    int n_chk = 0;
    int n_fail = 0;

    wire [4:0] ctl = {pc_hold, dec_hold, ex_bubble, flush, busy};
    wire [3:0] fwd = {fwd_a, fwd_b};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .Reset(Reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .br_taken(br_taken), .pc_hold(pc_hold), .dec_hold(dec_hold),
        .ex_bubble(ex_bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
    );

    // narrow counters and single-cycle flush for the boundary cases
    pipeline_hazard_ctrl #(.FLUSH_CYC(1), .CNT_W(4)) dut_s (
        .clk(clk), .Reset(Reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .br_taken(br_taken), .pc_hold(s_pc_hold), .dec_hold(s_dec_hold),
        .ex_bubble(s_ex_bubble), .flush(s_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .busy(s_busy)
    );

    task automatic idle();
        dec_valid = 0; dec_use1 = 0; dec_use2 = 0; dec_rs1 = 0; dec_rs2 = 0;
        ex_rd = 0; ex_wen = 0; ex_load = 0; wb_rd = 0; wb_wen = 0; br_taken = 0;
    endtask

    task automatic set_load_use();
        idle();
        dec_valid = 1; dec_rs2 = 7; dec_use2 = 1; ex_rd = 7; ex_wen = 1; ex_load = 1;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); Reset = 0;
        @(negedge clk); Reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset = 0; idle();
        dec_valid = 1; dec_use1 = 1; dec_rs1 = 2; ex_rd = 2; ex_wen = 1; br_taken = 1;
        #1;
        n_chk++; if ({ctl, fwd} !== 9'b0) begin n_fail++; $display("FAIL reset_outs: got %b want 000000000", {ctl, fwd}); end
        @(negedge clk); Reset = 1; idle(); #1;
        n_chk++; if ({stall_cnt, flush_cnt, busy} !== 33'b0) begin n_fail++; $display("FAIL reset_state: got stall=%h flush=%h busy=%b want 0 0 0", stall_cnt, flush_cnt, busy); end
    endtask

    task automatic test_independent();
        @(negedge clk); idle();
        dec_valid = 1; dec_use1 = 1; dec_use2 = 1; dec_rs1 = 4; dec_rs2 = 5; ex_rd = 3; ex_wen = 1; #1;
        n_chk++; if ({ctl, fwd} !== 9'b0) begin n_fail++; $display("FAIL indep: got %b want 000000000", {ctl, fwd}); end
        @(negedge clk); #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL indep_busy: got %b want 0", busy); end
    endtask

    task automatic test_alu_fwd();
        @(negedge clk); idle();
        dec_valid = 1; dec_use1 = 1; dec_rs1 = 2; dec_rs2 = 2; ex_rd = 2; ex_wen = 1; wb_rd = 2; wb_wen = 1; #1;
        n_chk++; if (fwd !== 4'b0100) begin n_fail++; $display("FAIL fwd_ex_prio: got %b want 0100", fwd); end
        ex_wen = 0; #1;
        n_chk++; if (fwd !== 4'b1000) begin n_fail++; $display("FAIL fwd_wb: got %b want 1000", fwd); end
        ex_wen = 1; ex_rd = 31; wb_rd = 31; dec_rs1 = 31; #1;
        n_chk++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL fwd_zero: got %b want 0000", fwd); end
        dec_valid = 0; dec_use1 = 0; dec_use2 = 1; dec_rs2 = 9; ex_rd = 9; ex_load = 1; wb_wen = 0; #1;
        n_chk++; if ({ctl, fwd} !== 9'b0) begin n_fail++; $display("FAIL load_no_fwd: got %b want 000000000", {ctl, fwd}); end
    endtask

    task automatic test_load_use();
        @(negedge clk); set_load_use(); #1;
        n_chk++; if ({ctl, fwd} !== 9'b11100_0000) begin n_fail++; $display("FAIL ldu_hold: got %b want 111000000", {ctl, fwd}); end
        @(negedge clk); idle();
        dec_valid = 1; dec_rs2 = 7; dec_use2 = 1; wb_rd = 7; wb_wen = 1; #1;
        n_chk++; if ({ctl, fwd} !== 9'b00001_0010) begin n_fail++; $display("FAIL ldstall: got %b want 000010010", {ctl, fwd}); end
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL ldu_cnt: got %0d want 1", stall_cnt); end
        @(negedge clk); idle(); #1;
        n_chk++; if ({ctl, stall_cnt} !== {5'b0, 16'd1}) begin n_fail++; $display("FAIL ldu_back: got ctl=%b cnt=%0d want 00000 1", ctl, stall_cnt); end
    endtask

    task automatic test_branch();
        @(negedge clk); idle(); br_taken = 1; #1;
        n_chk++; if ({ctl, flush_cnt} !== {5'b00010, 16'd0}) begin n_fail++; $display("FAIL br_detect: got ctl=%b cnt=%0d want 00010 0", ctl, flush_cnt); end
        n_chk++; if (s_flush !== 1'b1) begin n_fail++; $display("FAIL br1_detect: got %b want 1", s_flush); end
        @(negedge clk); set_load_use(); br_taken = 1; #1;
        n_chk++; if ({ctl, flush_cnt, stall_cnt} !== {5'b00111, 16'd1, 16'd1}) begin n_fail++; $display("FAIL br_flush: got ctl=%b fc=%0d sc=%0d want 00111 1 1", ctl, flush_cnt, stall_cnt); end
        n_chk++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL br1_busy: got %b want 0", s_busy); end
        @(negedge clk); idle(); #1;
        n_chk++; if ({ctl, flush_cnt} !== {5'b0, 16'd1}) begin n_fail++; $display("FAIL br_end: got ctl=%b cnt=%0d want 00000 1", ctl, flush_cnt); end
        n_chk++; if (s_flush_cnt !== 4'd2) begin n_fail++; $display("FAIL br1_cnt: got %0d want 2", s_flush_cnt); end
    endtask

    task automatic test_simul();
        do_reset();
        @(negedge clk); set_load_use(); br_taken = 1; #1;
        n_chk++; if (ctl !== 5'b00010) begin n_fail++; $display("FAIL sim_detect: got %b want 00010", ctl); end
        @(negedge clk); idle(); #1;
        n_chk++; if ({ctl, stall_cnt, flush_cnt} !== {5'b00111, 16'd0, 16'd1}) begin n_fail++; $display("FAIL sim_flush: got ctl=%b sc=%0d fc=%0d want 00111 0 1", ctl, stall_cnt, flush_cnt); end
        @(negedge clk); #1;
        n_chk++; if (ctl !== 5'b0) begin n_fail++; $display("FAIL sim_end: got %b want 00000", ctl); end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk); idle(); br_taken = 1;
        @(negedge clk); idle(); Reset = 0;
        dec_use1 = 1; dec_rs1 = 2; ex_rd = 2; ex_wen = 1; #1;
        n_chk++; if ({ctl, fwd} !== 9'b0) begin n_fail++; $display("FAIL rst_flush_outs: got %b want 000000000", {ctl, fwd}); end
        @(negedge clk); Reset = 1; #1;
        n_chk++; if ({ctl, fwd} !== 9'b00000_0100) begin n_fail++; $display("FAIL rst_flush_run: got %b want 000000100", {ctl, fwd}); end
        n_chk++; if ({stall_cnt, flush_cnt} !== 32'b0) begin n_fail++; $display("FAIL rst_flush_cnt: got sc=%0d fc=%0d want 0 0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); set_load_use();
            @(negedge clk); idle();
        end
        #1;
        n_chk++; if (s_stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %h want f", s_stall_cnt); end
        @(negedge clk); set_load_use();
        @(negedge clk); idle(); #1;
        n_chk++; if (s_stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h want f", s_stall_cnt); end
        n_chk++; if (stall_cnt !== 16'd16) begin n_fail++; $display("FAIL sat_wide: got %0d want 16", stall_cnt); end
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); br_taken = 1;
        end
        @(negedge clk); idle(); #1;
        n_chk++; if (s_flush_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_flush: got %h want f", s_flush_cnt); end
    endtask

    initial begin
        Reset = 0;
        idle();
        test_reset();
        test_independent();
        test_alu_fwd();
        test_load_use();
        test_branch();
        test_simul();
        test_reset_mid_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
